md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage, beside the combinational ALU.
//  - Executes MULT/MULTU/DIV/DIVU and writes the HI/LO register pair.
//  - Executes MTHI/MTLO and exposes HI/LO for MFHI/MFLO.
//  - Drives busy to the hazard unit, which stalls every later MD instruction while start|busy.

---
 rtl/md_unit_pkg.sv | 45 ++++
 rtl/md_unit.sv | 131 +++++++++++++
 tb/tb_md_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared opcode encoding, default latencies and op classification for md_unit.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package md_unit_pkg;

  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

  localparam int unsigned MD_MUL_LAT = 5;
  localparam int unsigned MD_DIV_LAT = 10;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MOVE,
    CLS_MUL,
    CLS_DIV
  } md_cls_e;

  // Map an opcode to its execution class; unknown or disabled codes are CLS_NONE
  function automatic md_cls_e md_class(input logic [MD_OP_W-1:0] op);
    md_cls_e cls;
    cls = CLS_NONE;
    case (op)
      MD_MULT, MD_MULTU: cls = CLS_MUL;
      MD_DIV, MD_DIVU:   cls = CLS_DIV;
      MD_MTHI, MD_MTLO:  cls = CLS_MOVE;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: cls = CLS_MUL;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Results are computed combinationally at accept, held in pend_*, and
// committed to HI/LO on the edge where the latency counter reaches zero.
// Optional feature macro: MD_MADD_EN (multiply-accumulate/subtract ops).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = MD_MUL_LAT,
  parameter int unsigned DIV_LAT = MD_DIV_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               start,
  input  logic               flush,
  input  logic [31:0]        inputA,
  input  logic [31:0]        inputB,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_we;

  md_cls_e          cls_c;
  logic             accept_c;
  logic             sgn_c;
  logic [63:0]      a_ext_c;
  logic [63:0]      b_ext_c;
  logic [63:0]      prod_c;
  logic [31:0]      a_mag_c;
  logic [31:0]      b_mag_c;
  logic [31:0]      b_div_c;
  logic [31:0]      q_mag_c;
  logic [31:0]      r_mag_c;
  logic [31:0]      q_c;
  logic [31:0]      r_c;
  logic [63:0]      res_c;
  logic             res_we_c;
  logic [CNT_W-1:0] lat_c;

  // Decode, accept qualification and shared multiply/divide datapath
  always_comb begin
    cls_c    = md_class(md_op);
    accept_c = start & ~flush & ~busy & (cls_c != CLS_NONE);
    sgn_c    = (md_op == MD_MULT) || (md_op == MD_DIV) ||
               (md_op == MD_MADD) || (md_op == MD_MSUB);

    a_ext_c  = sgn_c ? {{32{inputA[31]}}, inputA} : {32'd0, inputA};
    b_ext_c  = sgn_c ? {{32{inputB[31]}}, inputB} : {32'd0, inputB};
    prod_c   = a_ext_c * b_ext_c;

    // Signed division runs on magnitudes; a zero divisor is replaced to keep the divider defined
    a_mag_c  = (sgn_c && inputA[31]) ? -inputA : inputA;
    b_mag_c  = (sgn_c && inputB[31]) ? -inputB : inputB;
    b_div_c  = (b_mag_c == 32'd0) ? 32'd1 : b_mag_c;
    q_mag_c  = a_mag_c / b_div_c;
    r_mag_c  = a_mag_c % b_div_c;
    q_c      = (sgn_c && (inputA[31] ^ inputB[31])) ? -q_mag_c : q_mag_c;
    r_c      = (sgn_c && inputA[31]) ? -r_mag_c : r_mag_c;

    res_c    = 64'd0;
    res_we_c = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU: begin
        res_c    = prod_c;
        res_we_c = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        res_c    = {r_c, q_c};
        res_we_c = (inputB != 32'd0);
      end
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU: begin
        res_c    = {hi, lo} + prod_c;
        res_we_c = 1'b1;
      end
      MD_MSUB, MD_MSUBU: begin
        res_c    = {hi, lo} - prod_c;
        res_we_c = 1'b1;
      end
`endif
      default: begin
        res_c    = 64'd0;
        res_we_c = 1'b0;
      end
    endcase

    lat_c = (cls_c == CLS_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  end

  // Latency counter, pending result and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else if (accept_c) begin
      if (cls_c == CLS_MOVE) begin
        if (md_op == MD_MTHI) hi <= inputA;
        else                  lo <= inputA;
      end else begin
        pend_hi <= res_c[63:32];
        pend_lo <= res_c[31:0];
        pend_we <= res_we_c;
        cnt     <= lat_c;
        busy    <= 1'b1;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (pend_we) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (MD_MADD_EN aware).
module tb_md_unit;
  import md_unit_pkg::*;

  logic               clk;
  logic               reset;
  logic [MD_OP_W-1:0] md_op;
  logic               start;
  logic               flush;
  logic [31:0]        inputA;
  logic [31:0]        inputB;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;

  int checks = 0;
  int errors = 0;
  int cyc;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .start  (start),
    .flush  (flush),
    .inputA (inputA),
    .inputB (inputB),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single cycle, then count busy cycles (bounded)
  task automatic run_op(input logic [MD_OP_W-1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    @(negedge clk);
    md_op  = op;
    inputA = a;
    inputB = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    md_op  = MD_NONE;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    md_op  = MD_NONE;
    start  = 1'b0;
    flush  = 1'b0;
    inputA = 32'd0;
    inputB = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;

    // Multiply, signed and unsigned
    run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, cyc);
    chk("mult_cycles", 32'(cyc), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    chk("multu_cycles", 32'(cyc), 32'd5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // Divide, signed and unsigned, plus overflow corner
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    chk("div_cycles", 32'(cyc), 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(MD_DIVU, 32'd7, 32'd2, cyc);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);

    // Moves, then divide by zero leaves HI/LO untouched
    run_op(MD_MTHI, 32'hAAAA5555, 32'd0, cyc);
    chk("mthi_cycles", 32'(cyc), 32'd0);
    chk("mthi_hi", hi, 32'hAAAA5555);
    run_op(MD_MTLO, 32'hAAAA5555, 32'd0, cyc);
    chk("mtlo_lo", lo, 32'hAAAA5555);
    run_op(MD_DIV, 32'd5, 32'd0, cyc);
    chk("div0_cycles", 32'(cyc), 32'd10);
    chk("div0_hi", hi, 32'hAAAA5555);
    chk("div0_lo", lo, 32'hAAAA5555);

    // Starts while busy are ignored
    @(negedge clk);
    md_op  = MD_MULT;
    inputA = 32'h00010000;
    inputB = 32'h00010000;
    start  = 1'b1;
    cyc    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      start  = (i == 1) || (i == 2);
      md_op  = (i == 1) ? MD_MTHI : ((i == 2) ? MD_DIV : MD_NONE);
      inputA = (i == 1) ? 32'h1234 : 32'd100;
      inputB = 32'd3;
    end
    chk("ovl_cycles", 32'(cyc), 32'd5);
    chk("ovl_hi", hi, 32'd1);
    chk("ovl_lo", lo, 32'd0);

    // Flushed start is suppressed
    @(negedge clk);
    md_op  = MD_MULT;
    inputA = 32'hFFFFFFFF;
    inputB = 32'd2;
    start  = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    flush  = 1'b0;
    md_op  = MD_NONE;
    chk("flush_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("flush_hi", hi, 32'd1);
    chk("flush_lo", lo, 32'd0);

    // Asynchronous reset mid-divide
    @(negedge clk);
    md_op  = MD_DIV;
    inputA = 32'd100;
    inputB = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    md_op  = MD_NONE;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Multiply-accumulate
    run_op(MD_MTLO, 32'd5, 32'd0, cyc);
    run_op(MD_MADD, 32'd3, 32'd4, cyc);
`ifdef MD_MADD_EN
    chk("madd_cycles", 32'(cyc), 32'd5);
    chk("madd_lo", lo, 32'd17);
    chk("madd_hi", hi, 32'd0);
    run_op(MD_MSUBU, 32'd1, 32'd18, cyc);
    chk("msubu_hi", hi, 32'hFFFFFFFF);
    chk("msubu_lo", lo, 32'hFFFFFFFF);
`else
    chk("madd_off_cycles", 32'(cyc), 32'd0);
    chk("madd_off_lo", lo, 32'd5);
    chk("madd_off_hi", hi, 32'd0);
    run_op(MD_MSUBU, 32'd1, 32'd18, cyc);
    chk("msubu_off_lo", lo, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
